// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - handshake, ALU and result-record signals of the ALU issue stage
// slave is the issue stage; master is the surrounding pipeline plus ALU.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_pc;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [3:0]  alu_fn;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_negative;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] out_wdata;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_insn, in_rs1, in_rs2, in_pc,
    input  alu_out, alu_zero, alu_negative, out_ready,
    output in_ready, alu_v1, alu_v2, alu_fn,
    output out_valid, out_rd, out_we, out_wdata, out_taken, out_target, out_illegal
  );

  modport master (
    output in_valid, in_insn, in_rs1, in_rs2, in_pc,
    output alu_out, alu_zero, alu_negative, out_ready,
    input  in_ready, alu_v1, alu_v2, alu_fn,
    input  out_valid, out_rd, out_we, out_wdata, out_taken, out_target, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM/BRANCH issue stage around a combinational ALU
// Latches one instruction, drives the ALU for one cycle, then holds the result record.
module alu_issue #(
  parameter bit BACK2BACK = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [3:0]  fn;
  logic        dec_illegal;
  logic        is_alu;
  logic        is_branch;
  logic        sign_diff;
  logic        br_lt;
  logic        br_ltu;
  logic        br_taken;
  logic        in_ready;
  logic        accept;

  assign opcode = insn_q[6:0];
  assign funct3 = insn_q[14:12];
  assign funct7 = insn_q[31:25];
  assign imm_i  = {{20{insn_q[31]}}, insn_q[31:20]};
  assign imm_b  = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};

  always_comb begin
    v1          = rs1_q;
    v2          = rs2_q;
    fn          = {1'b0, funct3};
    dec_illegal = 1'b0;
    is_alu      = 1'b0;
    is_branch   = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        is_alu = 1'b1;
        if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          fn = 4'd8;
        end else if (funct7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        is_alu = 1'b1;
        v2     = imm_i;
        // Shift-immediates only accept a clean upper field; SRAI is not supported.
        if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        fn        = 4'd8;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // With differing signs the subtraction can overflow, so the MSBs decide directly.
  assign sign_diff = rs1_q[31] ^ rs2_q[31];
  assign br_lt     = sign_diff ? rs1_q[31] : bus.alu_negative;
  assign br_ltu    = sign_diff ? rs2_q[31] : bus.alu_negative;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = bus.alu_zero;
      3'b001:  br_taken = ~bus.alu_zero;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = ~br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = ~br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = BACK2BACK ? bus.out_ready : 1'b0;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & rst_n;
  end

  assign accept = in_ready & bus.in_valid;

  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    taken_d   = taken_q;
    target_d  = target_q;
    illegal_d = illegal_q;
    if (accept) begin
      insn_d = bus.in_insn;
      rs1_d  = bus.in_rs1;
      rs2_d  = bus.in_rs2;
      pc_d   = bus.in_pc;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rd_d      = insn_q[11:7];
        illegal_d = dec_illegal;
        we_d      = ~dec_illegal & is_alu & (insn_q[11:7] != 5'd0);
        wdata_d   = dec_illegal ? 32'd0 : bus.alu_out;
        taken_d   = ~dec_illegal & is_branch & br_taken;
        target_d  = (~dec_illegal & is_branch) ? (pc_q + imm_b) : 32'd0;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      insn_q    <= 32'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      pc_q      <= 32'd0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      wdata_q   <= 32'd0;
      taken_q   <= 1'b0;
      target_q  <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.alu_v1      = v1;
  assign bus.alu_v2      = v2;
  assign bus.alu_fn      = fn;
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_rd      = rd_q;
  assign bus.out_we      = we_q;
  assign bus.out_wdata   = wdata_q;
  assign bus.out_taken   = taken_q;
  assign bus.out_target  = target_q;
  assign bus.out_illegal = illegal_q;

endmodule
